prog_loader: RTL and testbench
==============================

# prog_loader

Synthesizable boot and run controller for the pipelined processor core. It zeroes the register file and the instruction/data memory, then streams a program into memory over a valid/ready port. It releases the core, counts run cycles until the core retires HLT or a cycle budget expires, and reports completion. It sits between the host/debug interface and the core's `REGISTER`/`MEMORY` write ports, and generalises the fixed clear/load/run sequence to any memory depth, word width and base address.

## Interface
- `DATA_W`, 32: instruction/memory word width.
- `MEM_DEPTH`, 1024: memory words; `AW = $clog2(MEM_DEPTH)`.
- `REG_COUNT`, 32: register-file entries; `RW = $clog2(REG_COUNT)`.
- `LOAD_BASE`, 0: first memory address written by the load stream.
- `CNT_W`, 16: cycle-counter width.
- `CLEAR_EN`, 1: 1 runs both clear phases; 0 skips them.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a session. Sampled only in IDLE or DONE.
- `max_cycles` in CNT_W: run budget. 0 means unlimited.
- `ld_valid` in 1, `ld_ready` out 1, `ld_data` in DATA_W, `ld_last` in 1: program stream.
- `reg_we` out 1, `reg_addr` out RW, `reg_wdata` out DATA_W: register-file write port.
- `mem_we` out 1, `mem_addr` out AW, `mem_wdata` out DATA_W: memory write port.
- `core_run` out 1: core enable. The core stalls while this is low.
- `core_halted` in 1: single-cycle pulse when HLT retires.
- `done` out 1, `timeout` out 1, `overflow` out 1: session status.
- `cycle_cnt` out CNT_W: run cycles elapsed.
- `words_loaded` out AW+1: words accepted.

## Operation
- States: IDLE, CLR_REG, CLR_MEM, LOAD, RUN, DONE.
- IDLE: `start` moves to CLR_REG, or to LOAD if `CLEAR_EN=0`. Entering from IDLE or DONE clears `cycle_cnt`, `words_loaded`, `timeout`, `overflow` and `done`.
- CLR_REG: `reg_we=1`, `reg_wdata=0`, `reg_addr` steps 0..REG_COUNT-1, one per cycle, then moves to CLR_MEM.
- CLR_MEM: `mem_we=1`, `mem_wdata=0`, `mem_addr` steps 0..MEM_DEPTH-1, then moves to LOAD.
- LOAD: `ld_ready=1`.
  - A handshake (`ld_valid & ld_ready`) writes `ld_data` to `LOAD_BASE + words_loaded` in the same cycle. `mem_we`, `mem_addr` and `mem_wdata` are combinational from the handshake. `words_loaded` increments.
  - A handshake with `ld_last=1` moves to RUN.
  - A handshake into address MEM_DEPTH-1 with `ld_last=0` is an implicit last: it sets sticky `overflow` and moves to RUN.
- RUN: `core_run=1`; `cycle_cnt` increments every cycle.
  - `core_halted` moves to DONE.
  - With `max_cycles≠0`, reaching `cycle_cnt==max_cycles` moves to DONE and sets `timeout`.
  - If halt and budget expiry occur in the same cycle, halt wins and `timeout=0`.
  - `cycle_cnt` saturates at all-ones.
- DONE: `done=1`, `core_run=0`. All status and counters hold. `start` begins a new session.
- `start` is ignored in CLR_REG, CLR_MEM, LOAD and RUN. `ld_ready=0` outside LOAD. `core_halted` is ignored outside RUN.
- At most one of `reg_we` and `mem_we` is active in any cycle.

## Timing
- Reset values: state IDLE; all outputs 0; counters 0. Reset mid-session drops `core_run`, `reg_we` and `mem_we` asynchronously. No partial write completes after `rst_n` falls.
- With `start` sampled at edge 0:
  - `reg_we` is high for cycles 1..REG_COUNT.
  - `mem_we` (clear) is high for cycles REG_COUNT+1..REG_COUNT+MEM_DEPTH.
  - `ld_ready` rises in cycle REG_COUNT+MEM_DEPTH+1.
- Load throughput is one word per cycle. Backpressure comes from `ld_valid` only.
- `core_run` rises in the cycle after the last handshake. `cycle_cnt` reads 1 after the first RUN edge.
- `done` rises in the cycle after `core_halted` or budget expiry. `core_run` falls in that same cycle.

## Structure
- Shared package `proc_pkg`: opcode constants (ADD..HLT), the `loader_state_t` enum, and `DATA_W`/`MEM_DEPTH`/`REG_COUNT` defaults shared with the core.
- One natural sub-module: `sat_counter` (parametrised width, enable, clear, saturate). It is instantiated for `cycle_cnt` and for the clear/address counter.

## Test plan
- Defaults, start, 17-word program (ADDI/ADD/SW/LW/BEQZ/BNEQZ/HLT sequence) with last on word 16 → regs 0..31 and mem 0..1023 written 0 in order; mem[0..16] hold program; `words_loaded=17`; `core_run` rises at cycle 1074.
- Halt pulse after 40 RUN cycles with `max_cycles=0` → `done=1`, `timeout=0`, `cycle_cnt=40`, `core_run=0` next cycle.
- `max_cycles=25`, no halt → `done=1`, `timeout=1`, `cycle_cnt=25`. Repeat with halt on cycle 25 → `timeout=0`.
- `MEM_DEPTH=16`, `LOAD_BASE=12`, 6 words, no last → words 0..3 written to 12..15; `overflow=1`, `words_loaded=4`, RUN entered.
- `ld_valid` toggling 1,0,0,1 with `CLEAR_EN=0` → only handshake cycles write; addresses consecutive; `start` mid-LOAD ignored.
- `rst_n` low mid-CLR_MEM, then start again → all outputs 0 during reset; new session restarts at reg address 0.

Source files
------------

// File: rtl/proc_pkg.sv
// Definitions shared between the pipelined core and its boot/run loader:
// opcodes, loader state encoding and default geometry.
package proc_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MEM_DEPTH = 1024;
  localparam int DEF_REG_COUNT = 32;

  localparam int OP_W = 6;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd1;
  localparam logic [OP_W-1:0] OP_AND   = 6'd2;
  localparam logic [OP_W-1:0] OP_OR    = 6'd3;
  localparam logic [OP_W-1:0] OP_SLT   = 6'd4;
  localparam logic [OP_W-1:0] OP_MUL   = 6'd5;
  localparam logic [OP_W-1:0] OP_LW    = 6'd8;
  localparam logic [OP_W-1:0] OP_SW    = 6'd9;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd10;
  localparam logic [OP_W-1:0] OP_SUBI  = 6'd11;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'd12;
  localparam logic [OP_W-1:0] OP_BNEQZ = 6'd13;
  localparam logic [OP_W-1:0] OP_BEQZ  = 6'd14;
  localparam logic [OP_W-1:0] OP_HLT   = 6'd63;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR_REG,
    ST_CLR_MEM,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear (priority over enable) that sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot and run controller: clears register file and memory, streams a program
// into memory, then runs the core until HLT or the cycle budget runs out.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start after reset
// ST_CLR_REG | writing zero to register 0..REG_COUNT-1, one per cycle
// ST_CLR_MEM | writing zero to memory 0..MEM_DEPTH-1, one per cycle
// ST_LOAD    | accepting program words, one per handshake
// ST_RUN     | core enabled, counting run cycles
// ST_DONE    | session finished, status and counters held
module prog_loader
  import proc_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter  int REG_COUNT = DEF_REG_COUNT,
  parameter  int LOAD_BASE = 0,
  parameter  int CNT_W     = 16,
  parameter  int CLEAR_EN  = 1,
  localparam int AW        = $clog2(MEM_DEPTH),
  localparam int RW        = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  max_cycles,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              reg_we,
  output logic [RW-1:0]     reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_run,
  input  logic              core_halted,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [AW:0]       words_loaded
);

  localparam int CW = (AW > RW) ? AW : RW;
  localparam int LW = AW + 1;

  loader_state_t state, state_nxt;

  logic [CW-1:0] addr_cnt;
  logic          addr_en, addr_clr;
  logic          start_go, hs, at_top, budget_hit, in_run;
  logic [AW:0]   ld_addr;

  assign start_go   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign hs         = ld_valid && (state == ST_LOAD);
  assign in_run     = (state == ST_RUN);
  assign ld_addr    = LW'(LOAD_BASE) + words_loaded;
  assign at_top     = (ld_addr == LW'(MEM_DEPTH - 1));
  // Compare the post-increment count so DONE is entered on the edge that makes cycle_cnt == max_cycles.
  assign budget_hit = (max_cycles != '0) && ((cycle_cnt + CNT_W'(1)) == max_cycles);

  sat_counter #(.W(CW)) u_addr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (addr_en),
    .clr   (addr_clr),
    .q     (addr_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (in_run),
    .clr   (start_go),
    .q     (cycle_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    reg_we    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ld_ready  = 1'b0;
    core_run  = 1'b0;
    done      = 1'b0;
    addr_en   = 1'b0;
    addr_clr  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        done = (state == ST_DONE);
        if (start) begin
          addr_clr  = 1'b1;
          state_nxt = (CLEAR_EN != 0) ? ST_CLR_REG : ST_LOAD;
        end
      end
      ST_CLR_REG: begin
        reg_we   = 1'b1;
        reg_addr = addr_cnt[RW-1:0];
        addr_en  = 1'b1;
        if (addr_cnt == CW'(REG_COUNT - 1)) begin
          addr_clr  = 1'b1;
          state_nxt = ST_CLR_MEM;
        end
      end
      ST_CLR_MEM: begin
        mem_we   = 1'b1;
        mem_addr = addr_cnt[AW-1:0];
        addr_en  = 1'b1;
        if (addr_cnt == CW'(MEM_DEPTH - 1)) begin
          addr_clr  = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_addr  = ld_addr[AW-1:0];
          mem_wdata = ld_data;
          if (ld_last || at_top) begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        core_run = 1'b1;
        if (core_halted || budget_hit) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_loaded <= '0;
      timeout      <= 1'b0;
      overflow     <= 1'b0;
    end else if (start_go) begin
      words_loaded <= '0;
      timeout      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (hs) begin
        words_loaded <= words_loaded + LW'(1);
        // Filling the top word without a last marker ends the stream early.
        if (at_top && !ld_last) begin
          overflow <= 1'b1;
        end
      end
      if (in_run && budget_hit && !core_halted) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized session bench for prog_loader across three geometries, checked
// against a memory/register image model and cycle-accurate latency rules.
module tb_prog_loader;
  import proc_pkg::*;

  typedef struct {
    int n;
    int last;
    int vmode;
    int halt;
    int maxc;
    int mid;
    int rst;
  } sess_t;

  localparam int NSESS = 6;

  logic clk = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] junk(int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0000_9E37);
  endfunction

  function automatic logic [31:0] prog_word(int i, bit hlt);
    logic [OP_W-1:0] op;
    case (i % 6)
      0:       op = OP_ADDI;
      1:       op = OP_ADD;
      2:       op = OP_SW;
      3:       op = OP_LW;
      4:       op = OP_BEQZ;
      default: op = OP_BNEQZ;
    endcase
    if (hlt) op = OP_HLT;
    return {op, 26'($urandom)};
  endfunction

  // Session table: -1 fields are randomized; the last session of each config is preceded by reset tests.
  function automatic sess_t scen(int g, int k);
    sess_t s;
    s = '{n: -1, last: 1, vmode: 1, halt: -1, maxc: -1, mid: 0, rst: 0};
    case (g * 8 + k)
      0:       s = '{17, 1, 0, 40, 0, 0, 0};
      1:       s = '{10, 1, 1, 0, 25, 0, 0};
      2:       s = '{8, 1, 1, 25, 25, 0, 0};
      8:       s = '{6, 0, 0, 0, 3, 0, 0};
      16:      s = '{5, 1, 2, 9, 0, 1, 0};
      17:      s.vmode = 2;
      default: ;
    endcase
    if (k == NSESS - 1) s.rst = 1;
    return s;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int G     = g;
    localparam int MD    = (g == 0) ? 1024 : (g == 1) ? 16 : 64;
    localparam int RC    = (g == 0) ? 32 : (g == 1) ? 4 : 8;
    localparam int BASE  = (g == 0) ? 0 : (g == 1) ? 12 : 5;
    localparam int CE    = (g == 2) ? 0 : 1;
    localparam int AW    = $clog2(MD);
    localparam int RW    = $clog2(RC);
    localparam int LW    = AW + 1;
    localparam int BOUND = RC + MD + 400;

    logic          rst_n, start, ld_valid, ld_ready, ld_last;
    logic          reg_we, mem_we, core_run, core_halted, done, timeout, overflow;
    logic [15:0]   max_cycles, cycle_cnt;
    logic [31:0]   ld_data, reg_wdata, mem_wdata;
    logic [RW-1:0] reg_addr;
    logic [AW-1:0] mem_addr;
    logic [AW:0]   words_loaded;
    logic          fin;
    logic [31:0]   mimg [MD];
    logic [31:0]   rimg [RC];

    prog_loader #(
      .MEM_DEPTH (MD),
      .REG_COUNT (RC),
      .LOAD_BASE (BASE),
      .CLEAR_EN  (CE)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .max_cycles   (max_cycles),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_data      (ld_data),
      .ld_last      (ld_last),
      .reg_we       (reg_we),
      .reg_addr     (reg_addr),
      .reg_wdata    (reg_wdata),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .core_run     (core_run),
      .core_halted  (core_halted),
      .done         (done),
      .timeout      (timeout),
      .overflow     (overflow),
      .cycle_cnt    (cycle_cnt),
      .words_loaded (words_loaded)
    );

    task automatic ck(input string t, input longint got, input longint exp);
      check_eq($sformatf("cfg%0d_%s", G, t), got, exp);
    endtask

    task automatic reset_test();
      rst_n = 1'b0;
      #1;
      ck("rst_in_done", {done, timeout, overflow, core_run, cycle_cnt, words_loaded}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (RC + MD / 2 - 1) @(negedge clk);
      ck("pre_rst_rdy", ld_ready, CE == 0);
      ck("pre_rst_we", mem_we, CE != 0);
      rst_n = 1'b0;
      #1;
      ck("rst_mid", {reg_we, mem_we, core_run, ld_ready, done, reg_addr, mem_addr}, 0);
      ck("rst_mid_data", mem_wdata, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    endtask

    task automatic run_session(input sess_t s);
      logic [31:0] prog [64];
      logic [31:0] e;
      int c, wi, runc, ldc, nreg, nclr, seq_err, ld_err, img_err;
      int first_reg, first_clr, last_clr, first_rdy, last_hs, first_run, done_cyc;
      int cap, exp_wl, exp_ovf, exp_len, exp_to, exp_rdy, exp_run;
      wi = 0; runc = 0; ldc = 0; nreg = 0; nclr = 0; seq_err = 0; ld_err = 0; img_err = 0;
      first_reg = -1; first_clr = -1; last_clr = -1; first_rdy = -1;
      last_hs = -1; first_run = -1; done_cyc = -1;
      for (int i = 0; i < 64; i++) prog[i] = prog_word(i, (s.last != 0) && (i == s.n - 1));
      for (int i = 0; i < MD; i++) mimg[i] = junk(i);
      for (int i = 0; i < RC; i++) rimg[i] = junk(i + 7);
      max_cycles = 16'(s.maxc);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      c = 1;
      while ((c <= BOUND) && (done_cyc < 0)) begin
        core_halted = core_run && (runc + 1 == s.halt);
        if (ld_ready && (wi < s.n)) begin
          ld_valid = (s.vmode == 0) || ((s.vmode == 1) && ($urandom_range(0, 3) != 0)) ||
                     ((s.vmode == 2) && ((ldc % 4 == 0) || (ldc % 4 == 3)));
          ld_data  = prog[wi];
          ld_last  = (s.last != 0) && (wi == s.n - 1);
        end else begin
          ld_valid = (s.vmode == 2);
          ld_data  = 32'hBAD0_0000 | 32'(c);
          ld_last  = 1'b0;
        end
        start = (s.mid != 0) && ld_ready && (ldc == 2);
        #1;
        if (reg_we) begin
          if (first_reg < 0) first_reg = c;
          if ((reg_addr != RW'(nreg)) || (reg_wdata != 0)) seq_err++;
          rimg[reg_addr] = reg_wdata;
          nreg++;
        end
        if (reg_we && mem_we) seq_err++;
        if (ld_ready) begin
          if (first_rdy < 0) first_rdy = c;
          ldc++;
          if (mem_we != ld_valid) ld_err++;
          if (mem_we) begin
            if ((int'(mem_addr) != BASE + wi) || (mem_wdata != prog[wi])) ld_err++;
            mimg[mem_addr] = mem_wdata;
            wi++;
            last_hs = c;
          end
        end else if (mem_we) begin
          if (first_clr < 0) first_clr = c;
          last_clr = c;
          if ((mem_addr != AW'(nclr)) || (mem_wdata != 0)) seq_err++;
          mimg[mem_addr] = mem_wdata;
          nclr++;
        end
        if (core_run) begin
          if (first_run < 0) first_run = c;
          runc++;
        end
        if (done) begin
          done_cyc = c;
        end else begin
          @(negedge clk);
          c++;
        end
      end

      cap = MD - BASE;
      if ((s.last != 0) && (s.n <= cap)) begin
        exp_wl = s.n; exp_ovf = 0;
      end else begin
        exp_wl = cap; exp_ovf = 1;
      end
      if ((s.halt != 0) && ((s.maxc == 0) || (s.halt <= s.maxc))) begin
        exp_len = s.halt; exp_to = 0;
      end else begin
        exp_len = s.maxc; exp_to = 1;
      end
      exp_rdy = (CE != 0) ? RC + MD + 1 : 1;
      exp_run = (s.vmode == 0) ? exp_rdy + exp_wl : last_hs + 1;

      ck("done_seen", done_cyc >= 0, 1);
      ck("run_off", core_run, 0);
      ck("cycle_cnt", cycle_cnt, exp_len);
      ck("timeout", timeout, exp_to);
      ck("overflow", overflow, exp_ovf);
      ck("words_loaded", words_loaded, exp_wl);
      ck("reg_first", first_reg, (CE != 0) ? 1 : -1);
      ck("reg_count", nreg, (CE != 0) ? RC : 0);
      ck("clr_first", first_clr, (CE != 0) ? RC + 1 : -1);
      ck("clr_last", last_clr, (CE != 0) ? RC + MD : -1);
      ck("rdy_first", first_rdy, exp_rdy);
      ck("seq_err", seq_err, 0);
      ck("ld_err", ld_err, 0);
      ck("run_first", first_run, exp_run);
      ck("run_cycles", runc, exp_len);
      ck("done_cycle", done_cyc, first_run + exp_len);

      for (int i = 0; i < MD; i++) begin
        e = ((i >= BASE) && (i < BASE + exp_wl)) ? prog[i - BASE] : ((CE != 0) ? 32'h0 : junk(i));
        if (mimg[i] != e) img_err++;
      end
      for (int i = 0; i < RC; i++) begin
        if (rimg[i] != ((CE != 0) ? 32'h0 : junk(i + 7))) img_err++;
      end
      ck("image", img_err, 0);

      core_halted = 1'b0;
      ld_valid    = 1'b0;
      ld_last     = 1'b0;
      start       = 1'b0;
      repeat (3) @(negedge clk);
      ck("hold", {done, cycle_cnt, words_loaded}, {1'b1, 16'(exp_len), LW'(exp_wl)});
    endtask

    initial begin
      sess_t s;
      fin         = 1'b0;
      rst_n       = 1'b0;
      start       = 1'b0;
      ld_valid    = 1'b0;
      ld_data     = '0;
      ld_last     = 1'b0;
      core_halted = 1'b0;
      max_cycles  = '0;
      repeat (3) @(negedge clk);
      ck("reset_ctl", {reg_we, reg_addr, mem_we, mem_addr, ld_ready, core_run, done,
                       timeout, overflow, cycle_cnt, words_loaded}, 0);
      ck("reset_wdata", {reg_wdata, mem_wdata}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NSESS; k++) begin
        s = scen(G, k);
        if (s.n < 0) s.n = int'($urandom_range(1, 40));
        if (s.halt < 0) s.halt = int'($urandom_range(0, 50));
        if (s.maxc < 0) s.maxc = int'($urandom_range(0, 50));
        if ((s.halt == 0) && (s.maxc == 0)) s.maxc = 13;
        if (s.rst != 0) reset_test();
        run_session(s);
      end
      fin = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) && (cyc < 40000)) begin
      @(posedge clk);
      cyc++;
    end
    check_eq("all_sessions_done", g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
